// File: rtl/pipe_ctrl_if.sv
// Bundle of IF/ID-side inputs and per-stage control outputs of the
// pipelined control unit. The master drives instruction fields, the
// slave (control unit) returns the stage control groups and enables.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
);
  logic [5:0]       opcode;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             branch_taken;
  logic [3:0]       idex_ex;
  logic [2:0]       idex_m;
  logic [1:0]       idex_wb;
  logic [2:0]       exmem_m;
  logic [1:0]       exmem_wb;
  logic [1:0]       memwb_wb;
  logic             pc_write;
  logic             ifid_write;
  logic             if_flush;
  logic             illegal_op;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output opcode, id_rs, id_rt, branch_taken,
    input  idex_ex, idex_m, idex_wb, exmem_m, exmem_wb, memwb_wb,
           pc_write, ifid_write, if_flush, illegal_op, stall_cnt
  );

  modport slave (
    input  opcode, id_rs, id_rt, branch_taken,
    output idex_ex, idex_m, idex_wb, exmem_m, exmem_wb, memwb_wb,
           pc_write, ifid_write, if_flush, illegal_op, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: decodes the ID opcode, carries EX/M/WB
// control groups through ID/EX, EX/MEM and MEM/WB, detects load-use
// hazards (one-cycle bubble), flushes on taken branch, flags illegal
// opcodes (sticky) and counts stall cycles with saturation.
module pipe_ctrl_unit #(
  parameter bit EXT_ISA = 1'b0,
  parameter int CNT_W   = 16,
  parameter int REG_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0]       dec_ex;
  logic [2:0]       dec_m;
  logic [1:0]       dec_wb;
  logic             dec_legal;
  logic             stall;

  logic [3:0]       idex_ex;
  logic [2:0]       idex_m;
  logic [1:0]       idex_wb;
  logic [REG_W-1:0] idex_rt;
  logic [2:0]       exmem_m;
  logic [1:0]       exmem_wb;
  logic [1:0]       memwb_wb;
  logic             illegal_op;
  logic [CNT_W-1:0] stall_cnt;

  // Opcode decode; every don't-care bit is forced to 0 and unknown opcodes become a bubble.
  always_comb begin
    dec_ex    = 4'b0000;
    dec_m     = 3'b000;
    dec_wb    = 2'b00;
    dec_legal = 1'b1;
    case (bus.opcode)
      OP_RTYPE: begin dec_ex = 4'b1100; dec_wb = 2'b10; end
      OP_LW:    begin dec_ex = 4'b0001; dec_m = 3'b010; dec_wb = 2'b11; end
      OP_SW:    begin dec_ex = 4'b0001; dec_m = 3'b001; end
      OP_BEQ:   begin dec_ex = 4'b0010; dec_m = 3'b100; end
      OP_NOP:   ;
      OP_ADDI: begin
        if (EXT_ISA) begin
          dec_ex = 4'b0001;
          dec_wb = 2'b10;
        end else begin
          dec_legal = 1'b0;
        end
      end
      default:  dec_legal = 1'b0;
    endcase
  end

  // Load-use hazard: the load in ID/EX writes a register the ID instruction reads (r0 excluded).
  always_comb begin
    stall = idex_m[1] & ((idex_rt == bus.id_rs) | (idex_rt == bus.id_rt)) & (idex_rt != '0);
  end

  // Stage registers with priority reset > flush > stall > normal advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_ex    <= '0;
      idex_m     <= '0;
      idex_wb    <= '0;
      idex_rt    <= '0;
      exmem_m    <= '0;
      exmem_wb   <= '0;
      memwb_wb   <= '0;
      illegal_op <= 1'b0;
      stall_cnt  <= '0;
    end else if (bus.branch_taken) begin
      idex_ex  <= '0;
      idex_m   <= '0;
      idex_wb  <= '0;
      idex_rt  <= '0;
      exmem_m  <= '0;
      exmem_wb <= '0;
      memwb_wb <= exmem_wb;
    end else if (stall) begin
      idex_ex  <= '0;
      idex_m   <= '0;
      idex_wb  <= '0;
      idex_rt  <= '0;
      exmem_m  <= idex_m;
      exmem_wb <= idex_wb;
      memwb_wb <= exmem_wb;
      if (stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end else begin
      idex_ex  <= dec_ex;
      idex_m   <= dec_m;
      idex_wb  <= dec_wb;
      // An illegal opcode enters as a bubble, so it carries no destination either.
      idex_rt  <= dec_legal ? bus.id_rt : '0;
      exmem_m  <= idex_m;
      exmem_wb <= idex_wb;
      memwb_wb <= exmem_wb;
      if (!dec_legal) begin
        illegal_op <= 1'b1;
      end
    end
  end

  // Output drive: a taken branch overrides the stall so the redirected fetch proceeds.
  always_comb begin
    bus.idex_ex    = idex_ex;
    bus.idex_m     = idex_m;
    bus.idex_wb    = idex_wb;
    bus.exmem_m    = exmem_m;
    bus.exmem_wb   = exmem_wb;
    bus.memwb_wb   = memwb_wb;
    bus.illegal_op = illegal_op;
    bus.stall_cnt  = stall_cnt;
    bus.pc_write   = ~stall | bus.branch_taken;
    bus.ifid_write = ~stall | bus.branch_taken;
    bus.if_flush   = bus.branch_taken;
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit. Two instances share the same stimulus:
// dut0 uses the default configuration, dut1 has EXT_ISA=1 and a 2-bit
// stall counter to exercise ADDI decode and counter saturation.
module tb_pipe_ctrl_unit;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  pipe_ctrl_if #(.CNT_W(16), .REG_W(5)) bus0 ();
  pipe_ctrl_if #(.CNT_W(2),  .REG_W(5)) bus1 ();

  pipe_ctrl_unit #(.EXT_ISA(1'b0), .CNT_W(16), .REG_W(5)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  pipe_ctrl_unit #(.EXT_ISA(1'b1), .CNT_W(2), .REG_W(5)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic bt);
    bus0.opcode = op; bus0.id_rs = rs; bus0.id_rt = rt; bus0.branch_taken = bt;
    bus1.opcode = op; bus1.id_rs = rs; bus1.id_rt = rt; bus1.branch_taken = bt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    n_total = 0;
    n_pass  = 0;

    // reset with RTYPE held
    rst_n = 1'b0;
    drive(OP_RTYPE, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    chk("rst_idex_ex",  32'(bus0.idex_ex),    32'h0);
    chk("rst_idex_m",   32'(bus0.idex_m),     32'h0);
    chk("rst_idex_wb",  32'(bus0.idex_wb),    32'h0);
    chk("rst_exmem_m",  32'(bus0.exmem_m),    32'h0);
    chk("rst_exmem_wb", 32'(bus0.exmem_wb),   32'h0);
    chk("rst_memwb_wb", 32'(bus0.memwb_wb),   32'h0);
    chk("rst_illegal",  32'(bus0.illegal_op), 32'h0);
    chk("rst_cnt",      32'(bus0.stall_cnt),  32'h0);
    chk("rst_pc_write", 32'(bus0.pc_write),   32'h1);
    rst_n = 1'b1;
    tick();
    chk("rel_idex_ex",  32'(bus0.idex_ex),  32'hC);
    chk("rel_idex_wb",  32'(bus0.idex_wb),  32'h2);
    tick();
    chk("rel_exmem_wb", 32'(bus0.exmem_wb), 32'h2);
    tick();
    chk("rel_memwb_wb", 32'(bus0.memwb_wb), 32'h2);

    // load-use: LW rt=5 then RTYPE rs=5
    drive(OP_LW, 5'd1, 5'd5, 1'b0);
    tick();
    chk("lw_idex_m", 32'(bus0.idex_m), 32'h2);
    drive(OP_RTYPE, 5'd5, 5'd2, 1'b0);
    chk("lu_pc_write",   32'(bus0.pc_write),   32'h0);
    chk("lu_ifid_write", 32'(bus0.ifid_write), 32'h0);
    tick();
    chk("lu_bub_ex",   32'(bus0.idex_ex),   32'h0);
    chk("lu_bub_m",    32'(bus0.idex_m),    32'h0);
    chk("lu_bub_wb",   32'(bus0.idex_wb),   32'h0);
    chk("lu_exmem_m",  32'(bus0.exmem_m),   32'h2);
    chk("lu_cnt",      32'(bus0.stall_cnt), 32'h1);
    chk("lu_pc_after", 32'(bus0.pc_write),  32'h1);
    tick();
    chk("lu_rtype_ex", 32'(bus0.idex_ex),   32'hC);
    chk("lu_cnt_hold", 32'(bus0.stall_cnt), 32'h1);

    // LW to r0 followed by a reader of r0: no hazard
    drive(OP_LW, 5'd1, 5'd0, 1'b0);
    tick();
    drive(OP_RTYPE, 5'd0, 5'd0, 1'b0);
    chk("r0_pc_write", 32'(bus0.pc_write), 32'h1);
    tick();
    chk("r0_idex_ex", 32'(bus0.idex_ex),   32'hC);
    chk("r0_cnt",     32'(bus0.stall_cnt), 32'h1);

    // branch flush while LW in ID/EX and a dependent SW in IF/ID
    drive(OP_LW, 5'd1, 5'd5, 1'b0);
    tick();
    chk("fl_exmem_wb_pre", 32'(bus0.exmem_wb), 32'h2);
    drive(OP_SW, 5'd5, 5'd3, 1'b1);
    chk("fl_if_flush", 32'(bus0.if_flush),   32'h1);
    chk("fl_pc_write", 32'(bus0.pc_write),   32'h1);
    chk("fl_ifid_wr",  32'(bus0.ifid_write), 32'h1);
    tick();
    chk("fl_idex_m",   32'(bus0.idex_m),    32'h0);
    chk("fl_exmem_m",  32'(bus0.exmem_m),   32'h0);
    chk("fl_exmem_wb", 32'(bus0.exmem_wb),  32'h0);
    chk("fl_memwb_wb", 32'(bus0.memwb_wb),  32'h2);
    chk("fl_cnt",      32'(bus0.stall_cnt), 32'h1);

    // illegal opcode held during a stall is not consumed, then flagged
    drive(OP_LW, 5'd1, 5'd5, 1'b0);
    tick();
    drive(OP_BAD, 5'd5, 5'd0, 1'b0);
    chk("il_stall_pc", 32'(bus0.pc_write), 32'h0);
    tick();
    chk("il_not_in_stall", 32'(bus0.illegal_op), 32'h0);
    chk("il_stall_cnt",    32'(bus0.stall_cnt),  32'h2);
    tick();
    chk("il_flag",    32'(bus0.illegal_op), 32'h1);
    chk("il_bub_ex",  32'(bus0.idex_ex),    32'h0);
    chk("il_bub_m",   32'(bus0.idex_m),     32'h0);
    chk("il_bub_wb",  32'(bus0.idex_wb),    32'h0);
    chk("il_flag_d1", 32'(bus1.illegal_op), 32'h1);

    // ADDI: illegal bubble without EXT_ISA, decoded with it
    drive(OP_ADDI, 5'd0, 5'd0, 1'b0);
    tick();
    chk("addi0_ex", 32'(bus0.idex_ex), 32'h0);
    chk("addi0_wb", 32'(bus0.idex_wb), 32'h0);
    chk("addi1_ex", 32'(bus1.idex_ex), 32'h1);
    chk("addi1_wb", 32'(bus1.idex_wb), 32'h2);
    drive(OP_RTYPE, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    chk("il_sticky", 32'(bus0.illegal_op), 32'h1);

    // reset asserted during a stall cycle wins
    drive(OP_LW, 5'd1, 5'd5, 1'b0);
    tick();
    drive(OP_RTYPE, 5'd5, 5'd2, 1'b0);
    chk("rs_stall_pc", 32'(bus0.pc_write), 32'h0);
    rst_n = 1'b0;
    tick();
    chk("rs_cnt",     32'(bus0.stall_cnt),  32'h0);
    chk("rs_cnt_d1",  32'(bus1.stall_cnt),  32'h0);
    chk("rs_exmem_m", 32'(bus0.exmem_m),    32'h0);
    chk("rs_illegal", 32'(bus0.illegal_op), 32'h0);
    rst_n = 1'b1;

    // five load-use stalls: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      drive(OP_LW, 5'd1, 5'd5, 1'b0);
      tick();
      drive(OP_RTYPE, 5'd5, 5'd2, 1'b0);
      tick();
      chk($sformatf("sat_cnt2_%0d", i),  32'(bus1.stall_cnt), 32'(sat_exp[i]));
      chk($sformatf("sat_cnt16_%0d", i), 32'(bus0.stall_cnt), 32'(i + 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
